pergate_accum_seq: RTL

//  Downstream of the per-gate gate-function stage. Takes the gate values at

---
 rtl/pergate_accum_seq_pkg.sv | 28 ++
 rtl/pergate_accum_seq_mul.sv | 52 +++++
 rtl/pergate_accum_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pergate_accum_seq_pkg.sv
// pergate_accum_seq_pkg
//   Shared field parameters, state encoding and modular-add helper for the
//   per-gate accumulator and its multiplier.
//   Field: 16-bit elements modulo the prime 65521.
package pergate_accum_seq_pkg;

  localparam int unsigned          F_NBITS = 16;
  localparam logic [F_NBITS-1:0]   F_Q     = 16'd65521;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // (a + b) mod F_Q for a, b < F_Q; a single conditional subtraction suffices.
  function automatic logic [F_NBITS-1:0] f_modadd(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
    logic [F_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, F_Q}) begin
      s = s - {1'b0, F_Q};
    end else begin
      s = s;
    end
    return s[F_NBITS-1:0];
  endfunction

endpackage

// File: rtl/pergate_accum_seq_mul.sv
// pergate_accum_seq_mul
//   Two-cycle field multiplier: out = a*b mod F_Q.
//   en is sampled on one edge, ready pulses high for one cycle two cycles
//   after en was high (latency Lmul = 2), with out valid while ready is high.
// Ports:
//   clk   in   clock
//   rstb  in   asynchronous active-low reset
//   en    in   launch a multiply with the current a, b
//   a, b  in   operands, < F_Q
//   ready out  one-cycle result-valid pulse
//   out   out  product mod F_Q
module pergate_accum_seq_mul
  import pergate_accum_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rstb,
  input  logic               en,
  input  logic [F_NBITS-1:0] a,
  input  logic [F_NBITS-1:0] b,
  output logic               ready,
  output logic [F_NBITS-1:0] out
);

  localparam logic [2*F_NBITS-1:0] Q_WIDE = (2*F_NBITS)'(F_Q);

  logic [2*F_NBITS-1:0] prod;
  logic                 prod_vld;

  // Stage 1 captures the full-width product, stage 2 reduces it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      ready    <= 1'b0;
      out      <= '0;
    end else begin
      prod_vld <= en;
      ready    <= prod_vld;
      if (en) begin
        prod <= {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
      end else begin
        prod <= prod;
      end
      if (prod_vld) begin
        out <= F_NBITS'(prod % Q_WIDE);
      end else begin
        out <= out;
      end
    end
  end

endmodule

// File: rtl/pergate_accum_seq.sv
// pergate_accum_seq
//   Per-gate accumulation of the sumcheck round polynomial shares:
//   acc[t] <= acc[t] + weight[t]*gatefn[t] mod F_Q for t = 0..NPOINTS-1,
//   processed one point at a time through a single shared multiplier.
//   A pass takes NPOINTS*(Lmul+1)+1 cycles from en to ready.
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   en      in   start one accumulate pass (single-cycle pulse, honoured when idle)
//   clr     in   zero all accumulators (honoured when idle, applied before en)
//   gatefn  in   gate values per point, held stable while ~ready
//   weight  in   per-point weights, held stable while ~ready
//   ready   out  idle and no start pending
//   acc     out  registered accumulators, always < F_Q
module pergate_accum_seq
  import pergate_accum_seq_pkg::*;
#(
  parameter int unsigned NPOINTS = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              clr,
  input  logic [NPOINTS-1:0][F_NBITS-1:0]   gatefn,
  input  logic [NPOINTS-1:0][F_NBITS-1:0]   weight,
  output logic                              ready,
  output logic [NPOINTS-1:0][F_NBITS-1:0]   acc
);

  localparam int unsigned IDX_W = (NPOINTS > 1) ? $clog2(NPOINTS) : 1;

  state_t             state;
  state_t             next_state;
  logic [IDX_W-1:0]   idx;
  logic               last_point;
  logic               mul_en;
  logic               mul_ready;
  logic [F_NBITS-1:0] mul_a;
  logic [F_NBITS-1:0] mul_b;
  logic [F_NBITS-1:0] mul_out;

  assign last_point = (idx == IDX_W'(NPOINTS - 1));

  pergate_accum_seq_mul u_mul (
    .clk   (clk),
    .rstb  (~rst),
    .en    (mul_en),
    .a     (mul_a),
    .b     (mul_b),
    .ready (mul_ready),
    .out   (mul_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a pass ends when the last point's product arrives.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (en) begin
          next_state = ST_MUL;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_ready && last_point) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_MUL;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs and operand selection; operands are don't-care outside a pass.
  always_comb begin
    ready = (state == ST_IDLE) && !en;
    if (state == ST_MUL) begin
      mul_a = weight[idx];
      mul_b = gatefn[idx];
    end else begin
      mul_a = {F_NBITS{1'bx}};
      mul_b = {F_NBITS{1'bx}};
    end
  end

  // Point index, multiplier launch pulse and accumulator updates.
  // clr is applied in the idle cycle itself, so clr+en clears then accumulates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      mul_en <= 1'b0;
      acc    <= '0;
    end else begin
      mul_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr) begin
            acc <= '0;
          end else begin
            acc <= acc;
          end
          if (en) begin
            idx    <= '0;
            mul_en <= 1'b1;
          end else begin
            idx <= idx;
          end
        end
        ST_MUL: begin
          if (mul_ready) begin
            acc[idx] <= f_modadd(acc[idx], mul_out);
            if (!last_point) begin
              idx    <= idx + IDX_W'(1);
              mul_en <= 1'b1;
            end else begin
              idx <= idx;
            end
          end else begin
            idx <= idx;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule
